memory_unit: RTL and testbench
==============================

# memory_unit

Memory-side responder for the control unit's memory command interface: executes `memory_op` and `address_reg_op` each cycle against a 16-bit address register and an on-chip byte RAM. Loads the address byte-wise from the shared 8-bit bus, reads and writes RAM, and drives the bus when selected. Sits between the control unit and the shared data bus, alongside the ALU and the general registers.

## Interface
Parameters:
- `MEM_ADDR_WIDTH`, 8: RAM index width. Depth is 2^MEM_ADDR_WIDTH bytes; upper address bits are ignored, so memory aliases.
- `ROM_TOP`, 16'h0040: first writable address. Used only with `MEMORY_PROTECT_EN`.

Ports:
- `clock`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: reset is asynchronous and active-high.
- `memory_op`  in  memory_op_e (2): MEM_NONE=0, MEM_READ=1, MEM_WRITE=2, 3 is reserved and treated as MEM_NONE.
- `address_reg_op`  in  address_reg_op_e (2): ADDR_NONE=0, ADDR_LOAD=1, ADDR_INC=2, ADDR_DEC=3.
- `data_word_selector`  in  1: on ADDR_LOAD, 0 loads the low byte and 1 loads the high byte.
- `bus_selector`  in  1: 1 makes the memory unit the bus driver.
- `bus_in`  in  8: shared bus value.
- `bus_out`  out  8: data register contents.
- `bus_drive`  out  1: output enable for `bus_out`.
- `address`  out  16: current address register, for debug and trace.
- `fault`  out  1: sticky write-protect violation flag. Tied to 0 when `MEMORY_PROTECT_EN` is not defined.

## Operation
- **State:**
  - `addr_reg[15:0]`
  - `data_reg[7:0]`
  - `fault_reg`
  - RAM array
- **MEM_READ:** `data_reg <= ram[addr_reg[MEM_ADDR_WIDTH-1:0]]`.
- **MEM_WRITE:**
  - `ram[idx] <= bus_in`.
  - `data_reg <= bus_in` (write-through).
- **ADDR_LOAD:** replaces the byte chosen by `data_word_selector` with `bus_in`. The other byte is unchanged.
- **ADDR_INC / ADDR_DEC:** modulo 2^16. 16'hFFFF+1 gives 16'h0000; 16'h0000-1 gives 16'hFFFF.
- **Memory op and address op in the same cycle:**
  - Both are executed.
  - The memory op always uses the pre-update address.
  - This covers fetch-and-advance (READ+INC) and write-then-load (WRITE+LOAD).
  - When WRITE and LOAD occur together, both consume the same `bus_in`.
- **Bus output:**
  - `bus_drive = bus_selector`, combinational.
  - `bus_out = data_reg`, always valid.
  - No internal bus-conflict detection.
- **Reset (asynchronous, any time, including mid-op):**
  - `addr_reg = 0`, `data_reg = 0`, `fault = 0`.
  - RAM contents are not reset.
  - An operation in the reset cycle has no effect.

## Timing
- Commands are sampled on the rising `clock` edge. The control unit changes commands on the falling edge, so commands are stable at sampling.
- Read latency is 1 cycle: data is in `data_reg` and on `bus_out` after the sampling edge. It is valid for a consumer in the next cycle.
- A write is visible to a MEM_READ of the same address on the next cycle.
- An address update is visible on `address` after the edge and is used by the next cycle's memory op.
- RAM is synchronous-write, synchronous-read. No combinational RAM-to-bus path.

## Configuration
- `MEMORY_PROTECT_EN` defined:
  - MEM_WRITE with `addr_reg < ROM_TOP` (full 16-bit compare) is suppressed. Both RAM and `data_reg` are left unchanged.
  - `fault_reg` is set to 1 and stays 1 until reset.
  - Address ops in the same cycle still execute.
- `MEMORY_PROTECT_EN` not defined:
  - All writes proceed.
  - `fault` is a constant 0.
  - `ROM_TOP` is unused.

## Structure
- `memory_op_e`, `address_reg_op_e` and their encodings live in package `control`, shared with the control unit.
- Add `MEM_ADDR_WIDTH_DEFAULT` to `control`.
- Sub-module `address_register`:
  - holds the 16-bit register with load-byte, increment and decrement;
  - takes async reset;
  - has ports `clock`, `reset`, `op`, `word_sel`, `data_in`, `value`.
- RAM, data register and protect logic stay in `memory_unit`.

## Test plan
- **Reset:** reset asserted mid-cycle → `address`=0, `bus_out`=0, `fault`=0 immediately. `bus_drive` follows `bus_selector`.
- **Byte load:** LOAD sel=0 bus=8'h34, then LOAD sel=1 bus=8'h12 → `address`=16'h1234. A further LOAD sel=0 bus=8'hFF → 16'h12FF.
- **Write then fetch:**
  - Write 8'hA5 @0x0050 and 8'h5A @0x0051.
  - Set address 0x0050, then READ+INC twice → `bus_out` = A5, then 5A; `address` ends at 0x0052.
- **Wrap and alias:**
  - 16'hFFFF + INC → 0x0000; 0x0000 + DEC → 0xFFFF.
  - With MEM_ADDR_WIDTH=8, a write of 8'h77 @0x0150 is read back @0x0050 as 77.
- **Protect (`MEMORY_PROTECT_EN`):**
  - WRITE 8'hEE @0x0010 → RAM unchanged, `fault`=1, and `fault` stays 1 after a later valid write @0x0040.
  - Without the macro, the same write lands and `fault`=0.
- **Simultaneous/reserved:**
  - WRITE+LOAD sel=0 bus=8'h99 at address 0x0060 → ram[0x60]=99, `address`=0x0099.
  - memory_op=3 → no RAM or `data_reg` change.

Source files
------------

// File: rtl/memory_unit_pkg.sv
// Shared command encodings between the control unit and the memory unit.
// Package name is `control` so the control unit can import the same definitions.
package control;

  // Default RAM index width (2^8 = 256 bytes of on-chip RAM).
  localparam int MEM_ADDR_WIDTH_DEFAULT = 8;

  // Memory command; MEM_RSVD is decoded exactly like MEM_NONE.
  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_RSVD  = 2'd3
  } memory_op_e;

  // Address register command.
  typedef enum logic [1:0] {
    ADDR_NONE = 2'd0,
    ADDR_LOAD = 2'd1,
    ADDR_INC  = 2'd2,
    ADDR_DEC  = 2'd3
  } address_reg_op_e;

  // Replace one byte of a 16-bit word; sel=0 low byte, sel=1 high byte.
  function automatic logic [15:0] load_byte(input logic [15:0] value,
                                            input logic        sel,
                                            input logic [7:0]  data);
    logic [15:0] result;
    result = value;
    if (sel) result[15:8] = data;
    else     result[7:0]  = data;
    return result;
  endfunction

endpackage

// File: rtl/memory_unit_address_register.sv
// 16-bit address register with byte load, increment and decrement.
// Increment/decrement wrap modulo 2^16. Asynchronous active-high reset.
module address_register
  import control::*;
(
  input  logic            clock,
  input  logic            reset,
  input  address_reg_op_e op,
  input  logic            word_sel,
  input  logic [7:0]      data_in,
  output logic [15:0]     value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // Next address from the requested operation.
  always_comb begin
    value_d = value_q;
    case (op)
      ADDR_LOAD: value_d = load_byte(value_q, word_sel, data_in);
      ADDR_INC:  value_d = value_q + 16'd1;
      ADDR_DEC:  value_d = value_q - 16'd1;
      default:   value_d = value_q;
    endcase
  end

  // Address register state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) value_q <= 16'h0000;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/memory_unit.sv
// Memory-side responder: executes memory_op and address_reg_op each cycle
// against a 16-bit address register and an on-chip byte RAM, and drives the
// shared 8-bit bus when selected.
//
// Optional feature: define MEMORY_PROTECT_EN to suppress writes below ROM_TOP
// and raise a sticky fault flag. Without it all writes proceed and fault is 0.
//
// Bus handshake: there is no valid/ready pair here. A command is valid for
// exactly the cycle it is presented and is always accepted at the next rising
// edge; bus_drive simply mirrors bus_selector and bus_out is always valid.
module memory_unit
  import control::*;
#(
  parameter int          MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEFAULT,
  parameter logic [15:0] ROM_TOP        = 16'h0040
) (
  input  logic            clock,
  input  logic            reset,
  input  memory_op_e      memory_op,
  input  address_reg_op_e address_reg_op,
  input  logic            data_word_selector,
  input  logic            bus_selector,
  input  logic [7:0]      bus_in,
  output logic [7:0]      bus_out,
  output logic            bus_drive,
  output logic [15:0]     address,
  output logic            fault
);

  localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;

  logic [15:0]               addr_q;
  logic [MEM_ADDR_WIDTH-1:0] ram_idx;
  logic [7:0]                ram_q [MEM_DEPTH];
  logic [7:0]                data_q;
  logic [7:0]                data_d;
  logic                      read_req;
  logic                      write_req;
  logic                      write_en;

  // The address register sees the same bus_in as a concurrent write; the
  // memory op below always uses addr_q, i.e. the pre-update address.
  address_register u_address_register (
    .clock    (clock),
    .reset    (reset),
    .op       (address_reg_op),
    .word_sel (data_word_selector),
    .data_in  (bus_in),
    .value    (addr_q)
  );

  // Upper address bits are ignored for RAM indexing, so memory aliases.
  assign ram_idx   = addr_q[MEM_ADDR_WIDTH-1:0];
  assign read_req  = (memory_op == MEM_READ);
  assign write_req = (memory_op == MEM_WRITE);

`ifdef MEMORY_PROTECT_EN
  logic protect_hit;
  logic fault_q;

  // A write below ROM_TOP (full 16-bit compare) is blocked entirely.
  assign protect_hit = write_req && (addr_q < ROM_TOP);
  assign write_en    = write_req && !protect_hit;

  // Sticky violation flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            fault_q <= 1'b0;
    else if (protect_hit) fault_q <= 1'b1;
  end

  assign fault = fault_q;
`else
  logic unused_protect_bits;

  assign write_en            = write_req;
  assign fault               = 1'b0;
  assign unused_protect_bits = ^{ROM_TOP, addr_q[15:MEM_ADDR_WIDTH]};
`endif

  // Data register next value: write-through on a write, RAM word on a read.
  always_comb begin
    data_d = data_q;
    if (write_en)      data_d = bus_in;
    else if (read_req) data_d = ram_q[ram_idx];
  end

  // Data register state; this is the only path from RAM to the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) data_q <= 8'h00;
    else       data_q <= data_d;
  end

  // RAM write port; contents survive reset but a reset cycle writes nothing.
  always_ff @(posedge clock) begin
    if (write_en && !reset) ram_q[ram_idx] <= bus_in;
  end

  assign bus_out   = data_q;
  assign bus_drive = bus_selector;
  assign address   = addr_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: a table of command vectors with
// hand-computed address/data/fault expectations, plus a hand-written
// asynchronous reset sequence.
module tb_memory_unit;
  import control::*;

`ifdef MEMORY_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  typedef struct {
    memory_op_e      mop;
    address_reg_op_e aop;
    logic            sel;
    logic            bsel;
    logic [7:0]      bin;
    logic [15:0]     exp_addr;
    logic [7:0]      exp_data;
    logic            chk_data;
    logic            exp_fault;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic            clock = 1'b0;
  logic            reset = 1'b1;
  memory_op_e      memory_op = MEM_NONE;
  address_reg_op_e address_reg_op = ADDR_NONE;
  logic            data_word_selector = 1'b0;
  logic            bus_selector = 1'b0;
  logic [7:0]      bus_in = 8'h00;
  logic [7:0]      bus_out;
  logic            bus_drive;
  logic [15:0]     address;
  logic            fault;

  always #5 clock = ~clock;

  memory_unit dut (
    .clock              (clock),
    .reset              (reset),
    .memory_op          (memory_op),
    .address_reg_op     (address_reg_op),
    .data_word_selector (data_word_selector),
    .bus_selector       (bus_selector),
    .bus_in             (bus_in),
    .bus_out            (bus_out),
    .bus_drive          (bus_drive),
    .address            (address),
    .fault              (fault)
  );

  // ---------------- scoreboard ----------------
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vec_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input memory_op_e mop, input address_reg_op_e aop,
                       input logic sel, input logic bsel, input logic [7:0] bin);
    @(negedge clock);
    memory_op          = mop;
    address_reg_op     = aop;
    data_word_selector = sel;
    bus_selector       = bsel;
    bus_in             = bin;
  endtask

  task automatic add(input memory_op_e mop, input address_reg_op_e aop, input logic sel,
                     input logic bsel, input logic [7:0] bin, input logic [15:0] ea,
                     input logic [7:0] ed, input logic cd, input logic ef);
    vec_t v;
    v.mop = mop; v.aop = aop; v.sel = sel; v.bsel = bsel; v.bin = bin;
    v.exp_addr = ea; v.exp_data = ed; v.chk_data = cd; v.exp_fault = ef;
    vec_q.push_back(v);
  endtask

  initial begin
    // ---- vector table ----
    // byte load
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'h34, 16'h0034, 8'h00, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 1, 1, 8'h12, 16'h1234, 8'h00, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'hFF, 16'h12FF, 8'h00, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 0, 1, 8'h50, 16'h1250, 8'h00, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 1, 0, 8'h00, 16'h0050, 8'h00, 1, 0);
    // write then fetch-and-advance
    add(MEM_WRITE, ADDR_INC,  0, 0, 8'hA5, 16'h0051, 8'hA5, 1, 0);
    add(MEM_WRITE, ADDR_NONE, 0, 1, 8'h5A, 16'h0051, 8'h5A, 1, 0);
    add(MEM_NONE,  ADDR_DEC,  0, 0, 8'h00, 16'h0050, 8'h5A, 1, 0);
    add(MEM_READ,  ADDR_INC,  0, 1, 8'h00, 16'h0051, 8'hA5, 1, 0);
    add(MEM_READ,  ADDR_INC,  0, 0, 8'h00, 16'h0052, 8'h5A, 1, 0);
    // wrap
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'hFF, 16'h00FF, 8'h5A, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 1, 0, 8'hFF, 16'hFFFF, 8'h5A, 1, 0);
    add(MEM_NONE,  ADDR_INC,  0, 1, 8'h00, 16'h0000, 8'h5A, 1, 0);
    add(MEM_NONE,  ADDR_DEC,  0, 0, 8'h00, 16'hFFFF, 8'h5A, 1, 0);
    // alias: write @0x0150 lands at ram[0x50]
    add(MEM_NONE,  ADDR_LOAD, 1, 0, 8'h01, 16'h01FF, 8'h5A, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'h50, 16'h0150, 8'h5A, 1, 0);
    add(MEM_WRITE, ADDR_NONE, 0, 0, 8'h77, 16'h0150, 8'h77, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 1, 0, 8'h00, 16'h0050, 8'h77, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'h51, 16'h0051, 8'h77, 1, 0);
    add(MEM_READ,  ADDR_NONE, 0, 0, 8'h00, 16'h0051, 8'h5A, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'h50, 16'h0050, 8'h5A, 1, 0);
    add(MEM_READ,  ADDR_NONE, 0, 1, 8'h00, 16'h0050, 8'h77, 1, 0);
    // reserved op: neither RAM nor data register change
    add(MEM_RSVD,  ADDR_NONE, 0, 0, 8'h11, 16'h0050, 8'h77, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'h51, 16'h0051, 8'h77, 1, 0);
    add(MEM_READ,  ADDR_NONE, 0, 0, 8'h00, 16'h0051, 8'h5A, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'h50, 16'h0050, 8'h5A, 1, 0);
    add(MEM_READ,  ADDR_NONE, 0, 0, 8'h00, 16'h0050, 8'h77, 1, 0);
    // write + load sharing bus_in, write uses pre-update address
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'h60, 16'h0060, 8'h77, 1, 0);
    add(MEM_WRITE, ADDR_LOAD, 0, 0, 8'h99, 16'h0099, 8'h99, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'h51, 16'h0051, 8'h99, 1, 0);
    add(MEM_READ,  ADDR_NONE, 0, 0, 8'h00, 16'h0051, 8'h5A, 1, 0);
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'h60, 16'h0060, 8'h5A, 1, 0);
    add(MEM_READ,  ADDR_NONE, 0, 0, 8'h00, 16'h0060, 8'h99, 1, 0);
    // protect region write @0x0010, then a legal write @0x0040
    add(MEM_NONE,  ADDR_LOAD, 0, 0, 8'h10, 16'h0010, 8'h99, 1, 0);
    add(MEM_WRITE, ADDR_NONE, 0, 0, 8'hEE, 16'h0010, PROT ? 8'h99 : 8'hEE, 1, PROT);
    add(MEM_READ,  ADDR_NONE, 0, 0, 8'h00, 16'h0010, 8'hEE, !PROT, PROT);
    add(MEM_NONE,  ADDR_LOAD, 0, 1, 8'h40, 16'h0040, 8'hEE, !PROT, PROT);
    add(MEM_WRITE, ADDR_NONE, 0, 0, 8'h3C, 16'h0040, 8'h3C, 1, PROT);
    add(MEM_READ,  ADDR_NONE, 0, 0, 8'h00, 16'h0040, 8'h3C, 1, PROT);

    // ---- reset state ----
    #2;
    check("reset_addr", address, 16'h0000);
    check("reset_data", {8'h00, bus_out}, 16'h0000);
    check("reset_fault", {15'h0, fault}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < vec_q.size(); i++) begin
      drive(vec_q[i].mop, vec_q[i].aop, vec_q[i].sel, vec_q[i].bsel, vec_q[i].bin);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_addr", i), address, vec_q[i].exp_addr);
      if (vec_q[i].chk_data)
        check($sformatf("vec%0d_data", i), {8'h00, bus_out}, {8'h00, vec_q[i].exp_data});
      check($sformatf("vec%0d_fault", i), {15'h0, fault}, {15'h0, vec_q[i].exp_fault});
      check($sformatf("vec%0d_drive", i), {15'h0, bus_drive}, {15'h0, vec_q[i].bsel});
    end

    // ---- asynchronous reset mid-cycle ----
    drive(MEM_READ, ADDR_LOAD, 1, 1, 8'h12);   // address 0x1240, data 3C
    @(posedge clock);
    #3;
    check("pre_reset_addr", address, 16'h1240);
    reset = 1'b1;
    #1;
    check("async_reset_addr", address, 16'h0000);
    check("async_reset_data", {8'h00, bus_out}, 16'h0000);
    check("async_reset_fault", {15'h0, fault}, 16'h0000);
    check("async_reset_drive1", {15'h0, bus_drive}, 16'h0001);
    bus_selector = 1'b0;
    #1;
    check("async_reset_drive0", {15'h0, bus_drive}, 16'h0000);

    // an operation presented while reset is held has no effect
    drive(MEM_WRITE, ADDR_LOAD, 0, 0, 8'h55);
    @(posedge clock);
    #1;
    check("reset_cycle_addr", address, 16'h0000);
    check("reset_cycle_data", {8'h00, bus_out}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;

    // RAM contents survive reset
    drive(MEM_NONE, ADDR_LOAD, 0, 0, 8'h50);
    @(posedge clock);
    #1;
    check("post_reset_addr", address, 16'h0050);
    drive(MEM_READ, ADDR_NONE, 0, 0, 8'h00);
    @(posedge clock);
    #1;
    check("ram_kept_data", {8'h00, bus_out}, 16'h0077);
    check("post_reset_fault", {15'h0, fault}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
